// File: rtl/rr_arbiter.sv
// rr_arbiter: registered round-robin / fixed-priority arbiter with hold timeout.
// Grants one of PORTS requesters. The grant is held until it is released by
// acknowledge or by request drop. It is also released when the hold counter expires.
// All outputs come straight from flops.
module rr_arbiter #(
  parameter int    PORTS        = 4,
  parameter int    ROUND_ROBIN  = 1,
  parameter int    BLOCK_ACK    = 1,
  parameter string LSB_PRIORITY = "HIGH",
  parameter int    MAX_HOLD     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS-1:0]         request,
  input  logic [PORTS-1:0]         acknowledge,
  output logic [PORTS-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(PORTS)-1:0] grant_encoded,
  output logic                     timeout
);

  localparam int IDX_W   = $clog2(PORTS);
  localparam bit LOW_PRI = (LSB_PRIORITY == "LOW");
  localparam int HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  // After reset the mask must be empty so the encoder's favourite port wins first.
  localparam logic [IDX_W-1:0]  LAST_RST  = LOW_PRI ? '0 : IDX_W'(PORTS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t             state_q, state_d;
  logic [PORTS-1:0]   grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   enc_q, enc_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic [PORTS-1:0]   masked;
  logic [IDX_W-1:0]   win_idx;
  logic [PORTS-1:0]   win_onehot;
  logic               rel_req;
  logic               release_now;
  logic               force_now;

  // Priority encoder: "HIGH" favours the lowest set index, "LOW" the highest.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [PORTS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (LOW_PRI) begin
      for (int i = 0; i < PORTS; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Keep only the ports that come after the last winner in priority order.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] last);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (LOW_PRI) m[i] = (IDX_W'(i) < last);
      else         m[i] = (IDX_W'(i) > last);
    end
    return m;
  endfunction

  // Winner selection and release detection, all from the current request/ack.
  always_comb begin
    masked     = (ROUND_ROBIN != 0) ? (request & rr_mask(last_q)) : '0;
    win_idx    = (|masked) ? prio_enc(masked) : prio_enc(request);
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
    rel_req     = (BLOCK_ACK != 0) ? acknowledge[enc_q] : ~request[enc_q];
    release_now = (state_q == GRANTED) && rel_req;
    force_now   = (state_q == GRANTED) && !rel_req && (MAX_HOLD != 0) &&
                  (hold_q == HOLD_LAST);
  end

  // Next-state logic: arbitrate when idle or on any release, else count hold cycles.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    enc_d     = enc_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if ((state_q == IDLE) || release_now || force_now) begin
      timeout_d = force_now;
      hold_d    = '0;
      if (|request) begin
        state_d = GRANTED;
        grant_d = win_onehot;
        valid_d = 1'b1;
        enc_d   = win_idx;
        last_d  = win_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
        enc_d   = '0;
      end
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end

  // State register; reset drops the grant immediately without a timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      enc_q     <= '0;
      last_q    <= LAST_RST;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      enc_q     <= enc_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = valid_q;
  assign grant_encoded = enc_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed checks of rr_arbiter in four parameterisations.
module tb_rr_arbiter;

  logic clk;
  logic rst;
  logic [3:0] req_a, ack_a, gnt_a;
  logic [3:0] req_b, ack_b, gnt_b;
  logic [3:0] req_c, ack_c, gnt_c;
  logic [3:0] req_d, ack_d, gnt_d;
  logic [1:0] enc_a, enc_b, enc_c, enc_d;
  logic       vld_a, vld_b, vld_c, vld_d;
  logic       to_a, to_b, to_c, to_d;

  int checks = 0;
  int errors = 0;

  // Defaults: round robin, ack release, "HIGH", no timeout.
  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(1), .LSB_PRIORITY("HIGH"), .MAX_HOLD(0)) u_a (
    .clk(clk), .rst(rst), .request(req_a), .acknowledge(ack_a), .grant(gnt_a),
    .grant_valid(vld_a), .grant_encoded(enc_a), .timeout(to_a));

  // Fixed priority, level release.
  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .BLOCK_ACK(0), .LSB_PRIORITY("HIGH"), .MAX_HOLD(0)) u_b (
    .clk(clk), .rst(rst), .request(req_b), .acknowledge(ack_b), .grant(gnt_b),
    .grant_valid(vld_b), .grant_encoded(enc_b), .timeout(to_b));

  // Ack release with a 3-cycle hold limit.
  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(1), .LSB_PRIORITY("HIGH"), .MAX_HOLD(3)) u_c (
    .clk(clk), .rst(rst), .request(req_c), .acknowledge(ack_c), .grant(gnt_c),
    .grant_valid(vld_c), .grant_encoded(enc_c), .timeout(to_c));

  // "LOW" priority, level release, single-cycle grants.
  rr_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .BLOCK_ACK(0), .LSB_PRIORITY("LOW"), .MAX_HOLD(1)) u_d (
    .clk(clk), .rst(rst), .request(req_d), .acknowledge(ack_d), .grant(gnt_d),
    .grant_valid(vld_d), .grant_encoded(enc_d), .timeout(to_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 4'b1010; ack_a = 4'b0000;
    req_b = 4'b1111; ack_b = 4'b0000;
    req_c = 4'b0000; ack_c = 4'b0000;
    req_d = 4'b0000; ack_d = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant_a", 32'(gnt_a), 32'h0);
    check("rst_valid_a", 32'(vld_a), 32'h0);
    check("rst_enc_a",   32'(enc_a), 32'h0);
    check("rst_to_a",    32'(to_a),  32'h0);
    check("rst_grant_b", 32'(gnt_b), 32'h0);
    rst = 1'b0;

    // First grant and ack-driven rotation
    step();
    check("first_grant_a", 32'(gnt_a), 32'h2);
    check("first_enc_a",   32'(enc_a), 32'h1);
    check("first_valid_a", 32'(vld_a), 32'h1);
    check("first_grant_b", 32'(gnt_b), 32'h1);
    step();
    check("hold_grant_a", 32'(gnt_a), 32'h2);
    check("hold_grant_b", 32'(gnt_b), 32'h1);
    ack_a = 4'b0010;
    step();
    ack_a = 4'b0000;
    check("rot1_grant_a", 32'(gnt_a), 32'h8);
    check("rot1_enc_a",   32'(enc_a), 32'h3);
    check("rot1_valid_a", 32'(vld_a), 32'h1);
    ack_a = 4'b1000;
    step();
    ack_a = 4'b0000;
    check("rot2_grant_a", 32'(gnt_a), 32'h2);
    check("rot2_valid_a", 32'(vld_a), 32'h1);
    ack_a = 4'b1000;
    step();
    ack_a = 4'b0000;
    check("spur_grant_a", 32'(gnt_a), 32'h2);

    // Fixed priority, level release
    req_b = 4'b1110;
    step();
    check("fix_grant_b", 32'(gnt_b), 32'h2);
    check("fix_enc_b",   32'(enc_b), 32'h1);
    req_b = 4'b0000;
    step();
    check("idle_grant_b", 32'(gnt_b), 32'h0);
    check("idle_valid_b", 32'(vld_b), 32'h0);

    // Hold timeout
    req_c = 4'b0011;
    step();
    check("to_c1_grant", 32'(gnt_c), 32'h1);
    step();
    check("to_c2_grant", 32'(gnt_c), 32'h1);
    step();
    check("to_c3_grant", 32'(gnt_c), 32'h1);
    check("to_c3_pulse", 32'(to_c),  32'h0);
    step();
    check("to_c4_grant", 32'(gnt_c), 32'h2);
    check("to_c4_pulse", 32'(to_c),  32'h1);
    check("to_c4_valid", 32'(vld_c), 32'h1);
    step();
    check("to_c5_grant", 32'(gnt_c), 32'h2);
    check("to_c5_pulse", 32'(to_c),  32'h0);
    step();
    check("to_c6_grant", 32'(gnt_c), 32'h2);
    // Ack in the third grant cycle: normal release, no pulse
    ack_c = 4'b0010;
    step();
    ack_c = 4'b0000;
    check("ackto_grant_c", 32'(gnt_c), 32'h1);
    check("ackto_pulse_c", 32'(to_c),  32'h0);
    ack_c = 4'b0010;
    step();
    ack_c = 4'b0000;
    check("spur_grant_c", 32'(gnt_c), 32'h1);
    check("spur_pulse_c", 32'(to_c),  32'h0);

    // "LOW" fairness: 3,2,1,0,3
    req_d = 4'b1111;
    step();
    check("low_r0_enc",   32'(enc_d), 32'h3);
    check("low_r0_pulse", 32'(to_d),  32'h0);
    step();
    check("low_r1_enc",   32'(enc_d), 32'h2);
    check("low_r1_pulse", 32'(to_d),  32'h1);
    step();
    check("low_r2_enc", 32'(enc_d), 32'h1);
    step();
    check("low_r3_enc", 32'(enc_d), 32'h0);
    check("low_r3_grant", 32'(gnt_d), 32'h1);
    step();
    check("low_r4_enc", 32'(enc_d), 32'h3);
    req_d = 4'b0100;
    step();
    check("low_pre_grant", 32'(gnt_d), 32'h4);

    // Asynchronous reset mid-grant
    #2;
    rst = 1'b1;
    #1;
    check("arst_grant_d", 32'(gnt_d), 32'h0);
    check("arst_valid_d", 32'(vld_d), 32'h0);
    check("arst_enc_d",   32'(enc_d), 32'h0);
    check("arst_to_d",    32'(to_d),  32'h0);
    check("arst_grant_a", 32'(gnt_a), 32'h0);
    #1;
    rst   = 1'b0;
    req_d = 4'b0101;
    step();
    check("low_first_grant", 32'(gnt_d), 32'h4);
    check("low_first_enc",   32'(enc_d), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Registered round-robin/fixed-priority arbiter that shares one downstream resource between `PORTS` requesters, built on the codebase's parameterised priority encoder. It sits in front of shared datapath elements and holds each grant until the requester releases it or a hold-timeout expires. Its outputs are a one-hot grant, a binary index and a valid flag. The index and valid outputs are format-compatible with the encoder's `output_encoded` and `output_valid`.

## Interface
- `PORTS`, 4, number of requesters; ≥2.
- `ROUND_ROBIN`, 1, 1 = rotating priority; 0 = fixed priority.
- `BLOCK_ACK`, 1:
  - 1 = a grant is held until `acknowledge` on the granted port.
  - 0 = a grant is held until `request` on the granted port drops.
- `LSB_PRIORITY`, "HIGH", "HIGH" = lower index wins ties; "LOW" = higher index wins.
- `MAX_HOLD`, 0, maximum grant length in cycles; 0 disables the timeout.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `request`  in  PORTS  per-port request level.
- `acknowledge`  in  PORTS  per-port release strobe; only meaningful when `BLOCK_ACK`=1.
- `grant`  out  PORTS  one-hot or zero; registered.
- `grant_valid`  out  1  equals `|grant`; registered.
- `grant_encoded`  out  $clog2(PORTS)  index of the granted port; 0 when idle.
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- **States:**
  - IDLE: `grant`=0.
  - GRANTED: exactly one `grant` bit is high; `last` holds its index.
- **Winner selection (combinational, from `request`):**
  - `masked` = `request` with the bits up to and including `last` cleared. For "HIGH" this is bits [last:0]; for "LOW" it is bits [PORTS-1:last].
  - The winner is the priority-encoded `masked` if it is nonzero; otherwise the priority-encoded `request`.
  - With `ROUND_ROBIN`=0, no mask is applied.
- **IDLE → GRANTED:** any `request` bit high at a clock edge. `grant`, `grant_encoded` and `last` load the winner.
- **Release condition for granted port g:**
  - `BLOCK_ACK`=1: `acknowledge[g]`=1.
  - `BLOCK_ACK`=0: `request[g]`=0.
  - `acknowledge` on non-granted ports is ignored.
- **On release:**
  - The same edge re-arbitrates, with the mask updated from g, so there is no idle bubble.
  - If no requests are present, the next state is IDLE.
  - g may win again only if it is the round-robin winner. In practice that means g is the sole requester, or `ROUND_ROBIN`=0.
- **Hold counter:**
  - Clears on every new grant and increments each cycle in GRANTED.
  - When it reaches `MAX_HOLD`-1 with no release, the next edge force-releases exactly as a normal release does.
  - The same edge sets `timeout`=1 for one cycle.
- **Simultaneous events:**
  - A release at the timeout edge is a normal release; `timeout` stays 0.
  - A request that drops in the same cycle it would win is simply not sampled.
- **Reset:**
  - Outputs are 0 (`grant`, `grant_valid`, `grant_encoded`, `timeout`) and the state is IDLE.
  - The hold counter is 0.
  - `last` is PORTS-1 for "HIGH" and 0 for "LOW", so the first grant goes to the port the priority encoder favours.
  - Assertion mid-grant drops `grant` immediately (asynchronously) with no `timeout` pulse.

## Timing
- **Latency:** a request sampled at edge n gives `grant` visible after edge n, i.e. one cycle.
- **Release to next grant:** release sampled at edge n gives the new grant after edge n.
  - Back-to-back grants are allowed with 0 idle cycles.
  - `grant_valid` stays high across the handover.
- **Maximum grant length:** exactly `MAX_HOLD` cycles, counted from the first cycle `grant` is high.
- **Timeout pulse:** `timeout` is high during the first cycle after a forced release.
- **Glitch-free outputs:** all outputs are registered; none is combinational from the inputs.
- **Fairness:** with all requests held and `ROUND_ROBIN`=1, `BLOCK_ACK`=0, `MAX_HOLD`=1, grants rotate 0,1,2,3,0,… ("HIGH") or 3,2,1,0,3,… ("LOW").

## Test plan
- **Reset and first grant.** Defaults; `request`=4'b1010 held from reset.
  - → After the first edge: `grant`=4'b0010, `grant_encoded`=1, `grant_valid`=1.
- **Rotation.** Pulse `acknowledge[1]`.
  - → Next cycle: `grant`=4'b1000, `grant_encoded`=3.
  - Pulse `acknowledge[3]` → `grant`=4'b0010 again, with no idle cycle at either handover.
- **Fixed priority, level release.** `ROUND_ROBIN`=0, `BLOCK_ACK`=0, `request`=4'b1111.
  - → Grant stays on 0.
  - Drop `request[0]` → grant moves to 1.
  - Drop all requests → `grant`=0, `grant_valid`=0 one cycle later.
- **Timeout.** `MAX_HOLD`=3; `request`=4'b0011 held, no acknowledge.
  - → `grant`=4'b0001 for exactly 3 cycles, then 4'b0010.
  - `timeout`=1 for one cycle, coincident with the first cycle of the new grant.
- **Ack coincident with timeout, and spurious ack.** `MAX_HOLD`=3; acknowledge the granted port in its 3rd grant cycle.
  - → Handover occurs with `timeout`=0.
  - `acknowledge` on a non-granted port → no change.
- **Mid-grant reset and "LOW" priority.** Assert `rst` while `grant`=4'b0100.
  - → All outputs are 0 without waiting for an edge.
  - After release with `LSB_PRIORITY`="LOW" and `request`=4'b0101 → `grant`=4'b0100.
